// File: rtl/cnn_concat_sched.sv
// cnn_concat_sched: drains NUM_IN branch FIFOs in fixed order into one registered stream per pixel.
module cnn_concat_sched #(
  parameter int NUM_IN     = 5,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16,
  parameter int SEL_WIDTH  = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [CNT_WIDTH-1:0]         cfg_seg_len,
  input  logic [CNT_WIDTH-1:0]         cfg_num_pix,
  input  logic [NUM_IN-1:0]            fifo_empty,
  input  logic [NUM_IN*DATA_WIDTH-1:0] fifo_dout,
  output logic [NUM_IN-1:0]            fifo_rd_en,
  output logic [DATA_WIDTH-1:0]        out,
  output logic                         valid_out,
  output logic [SEL_WIDTH-1:0]         cur_src,
  output logic                         busy,
  output logic                         done
);
  typedef enum logic [2:0] {IDLE, RUN, DRAIN1, DRAIN2, ZERO} state_t;
  localparam logic [SEL_WIDTH-1:0] SRC_LAST = SEL_WIDTH'(NUM_IN - 1);
  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);
  state_t state_q, state_d;
  logic [CNT_WIDTH-1:0] seg_q, seg_d, np_q, np_d, word_q, word_d, pix_q, pix_d;
  logic [SEL_WIDTH-1:0] src_q, src_d, src_dly_q;
  logic rd_dly_q, valid_q;
  logic [DATA_WIDTH-1:0] out_q, out_d;
  logic rd, seg_end, src_last, pix_last, last;
  assign seg_end  = word_q == seg_q - ONE;
  assign src_last = src_q == SRC_LAST;
  assign pix_last = pix_q == np_q - ONE;
  assign last     = rd && seg_end && src_last && pix_last;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      seg_q     <= '0;
      np_q      <= '0;
      word_q    <= '0;
      pix_q     <= '0;
      src_q     <= '0;
      src_dly_q <= '0;
      rd_dly_q  <= 1'b0;
      valid_q   <= 1'b0;
      out_q     <= '0;
    end else begin
      state_q   <= state_d;
      seg_q     <= seg_d;
      np_q      <= np_d;
      word_q    <= word_d;
      pix_q     <= pix_d;
      src_q     <= src_d;
      src_dly_q <= src_q;
      rd_dly_q  <= rd;
      valid_q   <= rd_dly_q;
      out_q     <= out_d;
    end
  end
  always_comb begin
    state_d = state_q;
    seg_d   = seg_q;
    np_d    = np_q;
    word_d  = word_q;
    pix_d   = pix_q;
    src_d   = src_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = (cfg_seg_len != '0 && cfg_num_pix != '0) ? RUN : ZERO;
        seg_d   = cfg_seg_len;
        np_d    = cfg_num_pix;
        word_d  = '0;
        pix_d   = '0;
        src_d   = '0;
      end
      RUN: if (rd) begin
        word_d  = seg_end ? '0 : word_q + ONE;
        src_d   = seg_end ? (src_last ? '0 : src_q + SEL_WIDTH'(1)) : src_q;
        pix_d   = (seg_end && src_last) ? (pix_last ? '0 : pix_q + ONE) : pix_q;
        state_d = last ? DRAIN1 : RUN;
      end
      DRAIN1:  state_d = DRAIN2;
      DRAIN2:  state_d = IDLE;
      ZERO:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // Read strobe is combinational so a word can be taken every cycle the current FIFO has data.
  always_comb begin
    rd         = state_q == RUN && !fifo_empty[src_q];
    fifo_rd_en = rd ? NUM_IN'(1) << src_q : '0;
    busy       = state_q != IDLE;
    done       = state_q == DRAIN2 || state_q == ZERO;
    cur_src    = src_q;
    out_d      = rd_dly_q ? fifo_dout[src_dly_q*DATA_WIDTH +: DATA_WIDTH] : out_q;
    out        = out_q;
    valid_out  = valid_q;
  end
endmodule

// File: tb/tb_cnn_concat_sched.sv
// tb_cnn_concat_sched: directed runs with FIFO models, expected words queued at launch and checked by a monitor.
module tb_cnn_concat_sched;
  localparam int N = 5, DW = 32, CW = 16, SW = 3, DEPTH = 16;
  typedef struct {logic [DW-1:0] d; logic last;} exp_t;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0, clr = 1'b0;
  logic [CW-1:0] seg_len = '0, num_pix = '0;
  logic [N-1:0] fifo_empty, rd_en, hold = '0;
  logic [N*DW-1:0] fifo_dout;
  logic [DW-1:0] out;
  logic valid_out, busy, done;
  logic [SW-1:0] cur_src;
  logic [DW-1:0] mem [N][DEPTH];
  logic [DW-1:0] dr [N];
  int rptr [N];
  exp_t exp_q[$];
  int rd_log[$];
  int tests = 0, fails = 0, cyc = 0, nout = 0, done_cnt = 0, zero_exp = 0;
  int first_rd = -1, first_val = -1, last_val = -1;

  cnn_concat_sched #(.NUM_IN(N), .DATA_WIDTH(DW), .CNT_WIDTH(CW), .SEL_WIDTH(SW)) dut (
    .clk(clk), .reset(reset), .start(start), .cfg_seg_len(seg_len), .cfg_num_pix(num_pix),
    .fifo_empty(fifo_empty), .fifo_dout(fifo_dout), .fifo_rd_en(rd_en), .out(out),
    .valid_out(valid_out), .cur_src(cur_src), .busy(busy), .done(done));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < N; g++) begin : g_fifo
    assign fifo_empty[g] = hold[g] || rptr[g] >= DEPTH;
    assign fifo_dout[g*DW +: DW] = dr[g];
  end

  always @(posedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (clr) rptr[k] <= 0;
      else if (rd_en[k] && rptr[k] < DEPTH) begin
        dr[k]   <= mem[k][rptr[k]];
        rptr[k] <= rptr[k] + 1;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      tests++;
      if (!$onehot0(rd_en) || (rd_en & fifo_empty) != '0) begin
        fails++;
        $display("FAIL rd_en: got %b with empty %b, required one-hot-or-zero on a non-empty FIFO", rd_en, fifo_empty);
      end
      for (int k = 0; k < N; k++) if (rd_en[k]) rd_log.push_back(k);
      if (rd_en != '0 && first_rd < 0) first_rd = cyc;
      if (valid_out) begin
        tests++;
        nout++;
        if (first_val < 0) first_val = cyc;
        last_val = cyc;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL stream: got unexpected word %0h, required no output", out);
        end else begin
          e = exp_q.pop_front();
          if (out !== e.d || done !== e.last) begin
            fails++;
            $display("FAIL stream: got out=%0h done=%b, required out=%0h done=%b", out, done, e.d, e.last);
          end
        end
      end else if (done) begin
        tests++;
        if (zero_exp == 0) begin
          fails++;
          $display("FAIL done: got done without a final word, required no done");
        end else zero_exp--;
      end
      if (done) done_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic prep(input int tid);
    for (int k = 0; k < N; k++)
      for (int j = 0; j < DEPTH; j++) mem[k][j] = DW'(tid << 8 | k << 4 | j);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    rd_log.delete();
    first_rd = -1;
    first_val = -1;
  endtask

  task automatic push_run(input int tid, input int s, input int p);
    for (int pi = 0; pi < p; pi++)
      for (int k = 0; k < N; k++)
        for (int w = 0; w < s; w++)
          exp_q.push_back('{DW'(tid << 8 | k << 4 | (pi * s + w)), pi == p - 1 && k == N - 1 && w == s - 1});
  endtask

  task automatic launch(input int s, input int p);
    seg_len = CW'(s);
    num_pix = CW'(p);
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0 = done_cnt;
    int i = 0;
    while (done_cnt == d0 && i < budget) begin
      tick(1);
      i++;
    end
    check("done_seen", 64'(done_cnt > d0), 64'd1);
    tick(2);
    check("drained", 64'(exp_q.size()), 64'd0);
    check("idle_after", 64'(busy), 64'd0);
  endtask

  initial begin
    int d0, n0, i, bad;
    tick(2);
    check("rst_out", 64'(out), 64'd0);
    check("rst_valid", 64'(valid_out), 64'd0);
    check("rst_busy_done", 64'({busy, done}), 64'd0);
    check("rst_src_rd", 64'({cur_src, rd_en}), 64'd0);
    reset = 1'b1;
    tick(1);

    // Case 1: one word per branch, two pixels, back-to-back.
    prep(1);
    push_run(1, 1, 2);
    d0 = done_cnt;
    n0 = nout;
    launch(1, 2);
    check("c1_busy", 64'(busy), 64'd1);
    wait_done(100);
    check("c1_count", 64'(nout - n0), 64'd10);
    check("c1_b2b", 64'(last_val - first_val), 64'd9);
    check("c1_one_done", 64'(done_cnt - d0), 64'd1);

    // Case 2: three words per branch, one pixel.
    prep(2);
    push_run(2, 3, 1);
    launch(3, 1);
    wait_done(100);
    check("c2_reads", 64'(rd_log.size()), 64'd15);
    bad = 0;
    for (int k = 0; k < rd_log.size(); k++) if (rd_log[k] != k / 3) bad++;
    check("c2_order", 64'(bad), 64'd0);
    check("c2_latency", 64'(first_val - first_rd), 64'd2);

    // Case 3: branch 2 stalls for 10 cycles.
    prep(3);
    hold[2] = 1'b1;
    push_run(3, 1, 2);
    launch(1, 2);
    i = 0;
    while (cur_src != 3'd2 && i < 50) begin
      tick(1);
      i++;
    end
    check("c3_reach", 64'(cur_src), 64'd2);
    tick(2);
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      if (rd_en != '0 || valid_out || cur_src != 3'd2) bad++;
      tick(1);
    end
    check("c3_stall", 64'(bad), 64'd0);
    hold[2] = 1'b0;
    wait_done(100);

    // Case 4: zero-length configs finish immediately without reads.
    prep(4);
    zero_exp = 1;
    d0 = done_cnt;
    launch(0, 3);
    check("c4_done_busy", 64'({done, busy, rd_en}), 64'({2'b11, 5'b0}));
    tick(1);
    check("c4_after", 64'({done, busy}), 64'd0);
    check("c4_one_done", 64'(done_cnt - d0), 64'd1);
    zero_exp = 1;
    launch(2, 0);
    check("c4b_done_busy", 64'({done, busy, rd_en}), 64'({2'b11, 5'b0}));
    tick(1);
    check("c4b_zero", 64'(zero_exp), 64'd0);
    check("c4b_reads", 64'(rd_log.size()), 64'd0);

    // Case 5: asynchronous reset mid-run, then a fresh run.
    prep(5);
    push_run(5, 1, 2);
    n0 = nout;
    launch(1, 2);
    i = 0;
    while (nout - n0 < 4 && i < 50) begin
      tick(1);
      i++;
    end
    check("c5_reach", 64'(nout - n0 >= 4), 64'd1);
    #2 reset = 1'b0;
    #1;
    check("c5_async", 64'({out, valid_out, busy, rd_en, cur_src}), 64'd0);
    exp_q.delete();
    tick(2);
    reset = 1'b1;
    tick(1);
    prep(6);
    push_run(6, 2, 1);
    launch(2, 1);
    wait_done(100);
    check("c5_restart_src", 64'(rd_log.size() > 0 ? rd_log[0] : -1), 64'd0);

    // Case 6: start and cfg changes while busy are ignored.
    prep(7);
    push_run(7, 2, 2);
    d0 = done_cnt;
    n0 = nout;
    launch(2, 2);
    tick(3);
    launch(5, 4);
    wait_done(200);
    tick(5);
    check("c6_one_done", 64'(done_cnt - d0), 64'd1);
    check("c6_count", 64'(nout - n0), 64'd20);
    check("c6_idle", 64'(busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of run, required completion");
    $fatal(1, "watchdog");
  end
endmodule
